// File: rtl/data_memory.sv
// Word-organised data RAM for the core's memory stage, with a debug/loader port
// that yields to core writes and sticky error flags for bad core addresses.
module data_memory #(
    parameter logic [31:0] base_addr   = 32'h0000_0000,
    parameter int unsigned depth_words = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_rd_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        err_misaligned,
    output logic        err_range,
    input  logic        err_clr
);

    localparam int unsigned AW   = $clog2(depth_words);
    localparam logic [31:0] SPAN = 32'(depth_words * 4);

    typedef enum logic [1:0] {
        DBG_IDLE,
        DBG_WAIT_WR,
        DBG_ACK
    } dbg_state_e;

    dbg_state_e state_q, state_d;

    logic [31:0] mem_q [depth_words];

    // Address decode; the unsigned subtraction makes addresses below base wrap
    // to a huge offset, so a single compare covers both ends of the window.
    logic [31:0]   core_off, dbg_off;
    logic          core_in_range, core_misaligned, core_ok, core_wr;
    logic          dbg_in_range;
    logic [AW-1:0] core_idx, dbg_idx;

    assign core_off        = data_addr - base_addr;
    assign core_in_range   = core_off < SPAN;
    assign core_misaligned = |data_addr[1:0];
    assign core_ok         = core_in_range & ~core_misaligned;
    assign core_idx        = core_off[AW+1:2];
    assign core_wr         = ~data_rd_wr;

    assign dbg_off      = dbg_addr - base_addr;
    assign dbg_in_range = dbg_off < SPAN;
    assign dbg_idx      = dbg_off[AW+1:2];

    logic          dbg_rd_fire, dbg_wr_fire, dbg_wr_ok, pend_load;
    logic [AW-1:0] dbg_wr_idx;
    logic [31:0]   dbg_wr_data;

    logic [AW-1:0] pend_idx_q, pend_idx_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic          pend_ok_q, pend_ok_d;

    logic [31:0] data_in_q, data_in_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        err_mis_q, err_mis_d;
    logic        err_rng_q, err_rng_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DBG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DBG_IDLE: begin
                if (dbg_req) begin
                    state_d = (dbg_we && core_wr) ? DBG_WAIT_WR : DBG_ACK;
                end
            end
            DBG_WAIT_WR: begin
                if (!core_wr) begin
                    state_d = DBG_ACK;
                end
            end
            default: state_d = DBG_IDLE;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        dbg_ack     = (state_q == DBG_ACK);
        dbg_rd_fire = 1'b0;
        dbg_wr_fire = 1'b0;
        pend_load   = 1'b0;
        dbg_wr_idx  = dbg_idx;
        dbg_wr_data = dbg_wdata;
        dbg_wr_ok   = dbg_in_range;
        case (state_q)
            DBG_IDLE: begin
                if (dbg_req) begin
                    dbg_rd_fire = ~dbg_we;
                    pend_load   = dbg_we & core_wr;
                    dbg_wr_fire = dbg_we & ~core_wr;
                end
            end
            DBG_WAIT_WR: begin
                dbg_wr_fire = ~core_wr;
                dbg_wr_idx  = pend_idx_q;
                dbg_wr_data = pend_data_q;
                dbg_wr_ok   = pend_ok_q;
            end
            default: ;
        endcase
    end

    // Single write port: the core owns it whenever it is writing, so the
    // debug write only ever fires in cycles where core_wr is low.
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;

    assign wr_en   = core_wr ? core_ok  : (dbg_wr_fire & dbg_wr_ok);
    assign wr_idx  = core_wr ? core_idx : dbg_wr_idx;
    assign wr_data = core_wr ? data_out : dbg_wr_data;

    // NOTE: the RAM array has no reset so it maps onto block RAM; contents
    // survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        data_in_d   = core_ok ? mem_q[core_idx] : 32'h0;
        dbg_rdata_d = dbg_rdata_q;
        if (dbg_rd_fire) begin
            dbg_rdata_d = dbg_in_range ? mem_q[dbg_idx] : 32'h0;
        end
        err_mis_d   = (err_mis_q & ~err_clr) | core_misaligned;
        err_rng_d   = (err_rng_q & ~err_clr) | ~core_in_range;
        pend_idx_d  = pend_load ? dbg_idx      : pend_idx_q;
        pend_data_d = pend_load ? dbg_wdata    : pend_data_q;
        pend_ok_d   = pend_load ? dbg_in_range : pend_ok_q;
    end

    // NOTE: non-blocking assignments here sample mem_q before this edge's
    // write lands, which is what gives read-first behaviour on collisions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_in_q   <= 32'h0;
            dbg_rdata_q <= 32'h0;
            err_mis_q   <= 1'b0;
            err_rng_q   <= 1'b0;
            pend_idx_q  <= '0;
            pend_data_q <= 32'h0;
            pend_ok_q   <= 1'b0;
        end else begin
            data_in_q   <= data_in_d;
            dbg_rdata_q <= dbg_rdata_d;
            err_mis_q   <= err_mis_d;
            err_rng_q   <= err_rng_d;
            pend_idx_q  <= pend_idx_d;
            pend_data_q <= pend_data_d;
            pend_ok_q   <= pend_ok_d;
        end
    end

    assign data_in        = data_in_q;
    assign dbg_rdata      = dbg_rdata_q;
    assign err_misaligned = err_mis_q;
    assign err_range      = err_rng_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a cycle-level behavioural model predicts
// data_in, error flags, ack timing and dbg_rdata; a monitor compares them.
module tb_data_memory;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic        clk, reset;
    logic        data_rd_wr, dbg_req, dbg_we, err_clr;
    logic [31:0] data_addr, data_out, dbg_addr, dbg_wdata;
    logic [31:0] data_in, dbg_rdata;
    logic        dbg_ack, err_misaligned, err_range;

    data_memory #(.base_addr(BASE), .depth_words(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .data_rd_wr(data_rd_wr), .data_addr(data_addr), .data_out(data_out),
        .data_in(data_in),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .err_misaligned(err_misaligned), .err_range(err_range),
        .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
        logic        rng;
        logic        ack;
    } exp_t;

    exp_t        core_q[$];
    logic [31:0] dbg_q[$];

    // Behavioural model state.
    logic [31:0] model [DEPTH];
    bit          mis_f, rng_f;
    logic [31:0] last_rdata;
    bit          d_pending, d_new, d_completed;
    bit          cur_we;
    logic [31:0] cur_addr, cur_wdata;
    bit          nreq_valid, nreq_we;
    logic [31:0] nreq_addr, nreq_wdata;
    logic [31:0] idle_addr;

    // Monitor: one expectation per clock edge, plus one rdata per ack.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (core_q.size() > 0) begin
                exp_t e;
                e = core_q.pop_front();
                check("data_in", data_in, e.data);
                check("err_misaligned", 32'(err_misaligned), 32'(e.mis));
                check("err_range", 32'(err_range), 32'(e.rng));
                check("dbg_ack", 32'(dbg_ack), 32'(e.ack));
                if (dbg_ack === 1'b1) begin
                    if (dbg_q.size() == 0) begin
                        check("dbg_ack_unexpected", 32'(1), 32'(0));
                    end else begin
                        check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
                    end
                end
            end
        end
    end

    // One clock of stimulus; expectations come from the model's old contents
    // so read-first collisions are predicted naturally.
    task automatic step(input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit clr);
        exp_t        e;
        bit          dropped, in_rng, mis, din;
        logic [31:0] off, doff;
        int unsigned idx, didx;
        @(negedge clk);
        dropped = 1'b0;
        if (d_completed) begin
            dbg_req     = 1'b0;
            dbg_we      = 1'b0;
            d_completed = 1'b0;
            dropped     = 1'b1;
        end
        if (nreq_valid && !d_pending && !dropped) begin
            cur_we     = nreq_we;
            cur_addr   = nreq_addr;
            cur_wdata  = nreq_wdata;
            dbg_req    = 1'b1;
            dbg_we     = cur_we;
            dbg_addr   = cur_addr;
            dbg_wdata  = cur_wdata;
            d_pending  = 1'b1;
            d_new      = 1'b1;
            nreq_valid = 1'b0;
        end
        off    = addr - BASE;
        in_rng = off < SPAN;
        mis    = addr[1:0] != 2'b00;
        idx    = off / 4;
        e.data = (in_rng && !mis) ? model[idx] : 32'h0;
        mis_f  = (mis_f && !clr) || mis;
        rng_f  = (rng_f && !clr) || !in_rng;
        e.mis  = mis_f;
        e.rng  = rng_f;
        e.ack  = 1'b0;
        if (d_pending) begin
            doff = cur_addr - BASE;
            din  = doff < SPAN;
            didx = doff / 4;
            if (!cur_we) begin
                if (d_new) begin
                    last_rdata = din ? model[didx] : 32'h0;
                    e.ack = 1'b1;
                end
            end else if (rd) begin
                if (din) model[didx] = cur_wdata;
                e.ack = 1'b1;
            end
            d_new = 1'b0;
        end
        if (!rd && in_rng && !mis) model[idx] = wdata;
        if (e.ack) begin
            dbg_q.push_back(last_rdata);
            d_pending   = 1'b0;
            d_completed = 1'b1;
        end
        core_q.push_back(e);
        data_rd_wr = rd;
        data_addr  = addr;
        data_out   = wdata;
        err_clr    = clr;
    endtask

    task automatic dbg_op(input bit we, input logic [31:0] a, input logic [31:0] d);
        nreq_valid = 1'b1;
        nreq_we    = we;
        nreq_addr  = a;
        nreq_wdata = d;
        for (int i = 0; i < 8 && (nreq_valid || d_pending); i++) begin
            step(1'b1, idle_addr, 32'h0, 1'b0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 15))
            0:       return BASE + SPAN + 4 * $urandom_range(0, 3);
            1:       return BASE - 4 * $urandom_range(1, 3);
            2:       return BASE + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
            3:       return BASE + SPAN - 4;
            4, 5:    return BASE + 4 * $urandom_range(0, DEPTH - 1);
            default: return BASE + 4 * $urandom_range(0, 7);
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        data_rd_wr = 1'b1;
        data_addr  = BASE;
        data_out   = 32'h0;
        dbg_req    = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = 32'h0;
        dbg_wdata  = 32'h0;
        err_clr    = 1'b0;
        mis_f = 0; rng_f = 0; last_rdata = 32'h0;
        d_pending = 0; d_new = 0; d_completed = 0; nreq_valid = 0;
        idle_addr = BASE + SPAN;

        #2 reset = 1'b0;
        #1;
        check("reset_data_in", data_in, 32'h0);
        check("reset_dbg_rdata", dbg_rdata, 32'h0);
        check("reset_dbg_ack", 32'(dbg_ack), 32'(0));
        check("reset_err_mis", 32'(err_misaligned), 32'(0));
        check("reset_err_rng", 32'(err_range), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Preload every word; the core idles on an out-of-range address.
        for (int i = 0; i < DEPTH; i++) begin
            dbg_op(1'b1, BASE + 32'(4 * i), $urandom | 32'h1);
        end
        idle_addr = BASE;
        step(1'b1, BASE, 32'h0, 1'b1);

        // Preload then core read, store then load.
        dbg_op(1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        step(1'b1, BASE + 32'h10, 32'h0, 1'b0);
        step(1'b0, BASE + 32'h8, 32'h1234_5678, 1'b0);
        step(1'b1, BASE + 32'h8, 32'h0, 1'b0);

        // Debug write blocked by three core writes.
        nreq_valid = 1'b1; nreq_we = 1'b1;
        nreq_addr = BASE + 32'h20; nreq_wdata = 32'hCAFE_F00D;
        step(1'b0, BASE + 32'h24, 32'h1111_1111, 1'b0);
        step(1'b0, BASE + 32'h28, 32'h2222_2222, 1'b0);
        step(1'b0, BASE + 32'h2C, 32'h3333_3333, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'h20 + 32'(4 * i), 32'h0, 1'b0);

        // Error flags, clear, and clear colliding with a new error.
        step(1'b1, BASE + 32'h6, 32'h0, 1'b0);
        step(1'b0, BASE + SPAN, 32'hFFFF_FFFF, 1'b0);
        dbg_op(1'b0, BASE, 32'h0);
        dbg_op(1'b0, BASE + SPAN, 32'h0);
        step(1'b1, BASE, 32'h0, 1'b1);
        step(1'b1, BASE + 32'h1, 32'h0, 1'b1);
        step(1'b1, BASE - 32'h4, 32'h0, 1'b0);
        step(1'b1, BASE + SPAN - 4, 32'h0, 1'b1);
        dbg_op(1'b0, BASE + 32'h13, 32'h0);

        // Async reset while a debug write waits behind core writes.
        step(1'b1, BASE + 32'h2, 32'h0, 1'b0);
        nreq_valid = 1'b1; nreq_we = 1'b1;
        nreq_addr = BASE + 32'h10; nreq_wdata = 32'h0BAD_F00D;
        step(1'b0, BASE + 32'h30, 32'h5555_5555, 1'b0);
        step(1'b0, BASE + 32'h34, 32'h6666_6666, 1'b0);
        @(negedge clk);
        data_rd_wr = 1'b1;
        dbg_req    = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_data_in", data_in, 32'h0);
        check("midrst_dbg_rdata", dbg_rdata, 32'h0);
        check("midrst_dbg_ack", 32'(dbg_ack), 32'(0));
        check("midrst_err_mis", 32'(err_misaligned), 32'(0));
        check("midrst_err_rng", 32'(err_range), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        mis_f = 0; rng_f = 0; last_rdata = 32'h0;
        d_pending = 0; d_new = 0; d_completed = 0; nreq_valid = 0;
        step(1'b1, BASE + 32'h10, 32'h0, 1'b0);
        dbg_op(1'b0, BASE + 32'h10, 32'h0);
        step(1'b1, BASE + 32'h34, 32'h0, 1'b0);

        // Randomized traffic with concurrent debug requests.
        for (int n = 0; n < 1500; n++) begin
            if (!nreq_valid && !d_pending && $urandom_range(0, 3) == 0) begin
                nreq_valid = 1'b1;
                nreq_we    = $urandom_range(0, 1) == 1;
                nreq_addr  = rand_addr() | 32'($urandom_range(0, 3));
                nreq_wdata = $urandom;
            end
            step($urandom_range(0, 9) < 6, rand_addr(), $urandom,
                 $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, BASE, 32'h0, 1'b0);

        @(posedge clk);
        #2;
        check("core_q_drained", 32'(core_q.size()), 32'(0));
        check("dbg_q_drained", 32'(dbg_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
